race_controller: RTL and testbench
==================================

RACE_CONTROLLER -- requirements
Module: race_controller

Interface
REQ-001 Parameter N_OBS, default 6: number of obstacle channels, 1..16.
REQ-002 Parameter CAR_W, default 16: car bounding-box width in pixels.
REQ-003 Parameter CAR_H, default 32: car bounding-box height in pixels.
REQ-004 Parameter LIVES_INIT, default 3: lives loaded at game start, 1..15.
REQ-005 Parameter CRASH_TICKS, default 60: upsig ticks spent in CRASH, 1..255.
REQ-006 clk  in  1  single system clock; all logic on posedge clk.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 upsig  in  1  one-cycle game-tick strobe.
REQ-009 start  in  1  level; start/restart request.
REQ-010 player_x  in  8 ; player_y  in  10  player car position.
REQ-011 obs_on  in  N_OBS  per-obstacle valid; obs_x  in  8*N_OBS; obs_y  in  10*N_OBS; channel i at slice i.
REQ-012 alive  out  1  game running; enables scroll and score.
REQ-013 crash  out  1  high throughout CRASH.
REQ-014 game_over  out  1  high in OVER.
REQ-015 lives  out  4  remaining lives.
REQ-016 hit_vec  out  N_OBS  registered per-obstacle overlap; hit_idx  out  4  lowest set index of last crash.

Function
REQ-017 Overlap(i) SHALL be obs_on[i] AND |obs_x_i - player_x| < CAR_W AND |obs_y_i - player_y| < CAR_H, differences computed unsigned-safe at width+1 bits.
REQ-018 hit_vec SHALL register overlap every clk; latency one cycle from inputs.
REQ-019 States: IDLE, RUN, CRASH, OVER (plus GRACE per REQ-030).
REQ-020 IDLE: start=1 -> RUN, lives <= LIVES_INIT, hit_vec ignored.
REQ-021 RUN: |hit_vec -> CRASH the next cycle; lives decremented by one on entry; hit_idx <= lowest set bit of hit_vec.
REQ-022 CRASH: tick counter SHALL clear on entry and advance only on upsig; at CRASH_TICKS-th upsig -> OVER if lives==0, else RUN (or GRACE).
REQ-023 OVER: start=1 -> IDLE; start held high SHALL NOT re-enter RUN until a rising edge of start is seen in IDLE.
REQ-024 alive=1 only in RUN/GRACE; crash=1 only in CRASH; game_over=1 only in OVER; all outputs registered.
REQ-025 lives SHALL saturate at 0; never wrap.
REQ-026 Collisions arriving in CRASH, OVER or IDLE SHALL be ignored; multiple simultaneous hits cost one life.
REQ-027 upsig coincident with the CRASH entry cycle SHALL NOT count.

Reset
REQ-028 reset SHALL force IDLE, lives=0, hit_vec=0, hit_idx=0, tick counter=0, alive=crash=game_over=0, start-edge detector primed so start already high is not an edge.
REQ-029 reset mid-CRASH SHALL abandon the crash with no further life change.

Configuration
REQ-030 RACE_CONTROLLER_GRACE_EN defined: CRASH exits non-fatally to GRACE, alive=1, collisions ignored for CRASH_TICKS upsig ticks, then RUN; undefined: CRASH exits directly to RUN, GRACE state absent.

Structure
REQ-031 State encoding, car-geometry defaults and position widths (8/10) SHALL live in a shared package race_pkg.
REQ-032 Per-obstacle overlap SHALL be a sub-module box_overlap instantiated N_OBS times via generate.

Verification
REQ-033 Reset, start pulse -> RUN next cycle, lives=3, alive=1.
REQ-034 Player (100,400), obstacle 2 at (110,420) on -> hit_vec=0b000100 next cycle, CRASH cycle after, lives=2, hit_idx=2.
REQ-035 Obstacle at dx=16 exactly or obs_on=0 at identical position -> no hit.
REQ-036 Obstacles 1 and 4 overlapping together -> one life lost, hit_idx=1; CRASH lasts exactly 60 upsig pulses.
REQ-037 Three crashes from LIVES_INIT=3 -> OVER, lives=0, game_over=1; start held high stays IDLE until re-asserted.
REQ-038 With RACE_CONTROLLER_GRACE_EN, overlap held through GRACE -> no second CRASH until GRACE ends.

Source files
------------

// File: rtl/race_pkg.sv
// Shared types, geometry defaults and position widths for the race controller.
// RACE_CONTROLLER_GRACE_EN adds the GRACE state to the state encoding.
package race_pkg;

    localparam int POS_X_W   = 8;
    localparam int POS_Y_W   = 10;
    localparam int CAR_W_DEF = 16;
    localparam int CAR_H_DEF = 32;
    localparam int LIVES_W   = 4;
    localparam int IDX_W     = 4;
    localparam int TICK_W    = 8;
    localparam int MAX_OBS   = 16;

`ifdef RACE_CONTROLLER_GRACE_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_CRASH = 3'd2,
        ST_OVER  = 3'd3,
        ST_GRACE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_CRASH = 3'd2,
        ST_OVER  = 3'd3
    } state_t;
`endif

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_OBS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = MAX_OBS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational bounding-box overlap test between the player car and one obstacle.
// Differences are taken one bit wider than the coordinates so they never wrap.
module box_overlap
    import race_pkg::*;
#(
    parameter int CAR_W = CAR_W_DEF,
    parameter int CAR_H = CAR_H_DEF
) (
    input  logic               on_i,
    input  logic [POS_X_W-1:0] obs_x_i,
    input  logic [POS_Y_W-1:0] obs_y_i,
    input  logic [POS_X_W-1:0] player_x_i,
    input  logic [POS_Y_W-1:0] player_y_i,
    output logic               hit_o
);

    localparam logic [POS_X_W:0] W_LIM = (POS_X_W + 1)'(CAR_W);
    localparam logic [POS_Y_W:0] H_LIM = (POS_Y_W + 1)'(CAR_H);

    logic [POS_X_W:0] dx;
    logic [POS_Y_W:0] dy;

    always_comb begin
        if (obs_x_i >= player_x_i) dx = {1'b0, obs_x_i} - {1'b0, player_x_i};
        else                       dx = {1'b0, player_x_i} - {1'b0, obs_x_i};
        if (obs_y_i >= player_y_i) dy = {1'b0, obs_y_i} - {1'b0, player_y_i};
        else                       dy = {1'b0, player_y_i} - {1'b0, obs_y_i};
        hit_o = on_i && (dx < W_LIM) && (dy < H_LIM);
    end

endmodule

// File: rtl/race_controller.sv
// Game-state controller: collision detection, lives, crash timing and game over.
// Define RACE_CONTROLLER_GRACE_EN for an invulnerable GRACE period after each crash.
module race_controller
    import race_pkg::*;
#(
    parameter int N_OBS       = 6,
    parameter int CAR_W       = CAR_W_DEF,
    parameter int CAR_H       = CAR_H_DEF,
    parameter int LIVES_INIT  = 3,
    parameter int CRASH_TICKS = 60
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     upsig,
    input  logic                     start,
    input  logic [POS_X_W-1:0]       player_x,
    input  logic [POS_Y_W-1:0]       player_y,
    input  logic [N_OBS-1:0]         obs_on,
    input  logic [POS_X_W*N_OBS-1:0] obs_x,
    input  logic [POS_Y_W*N_OBS-1:0] obs_y,
    output logic                     alive,
    output logic                     crash,
    output logic                     game_over,
    output logic [LIVES_W-1:0]       lives,
    output logic [N_OBS-1:0]         hit_vec,
    output logic [IDX_W-1:0]         hit_idx
);

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(CRASH_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_LD  = LIVES_W'(LIVES_INIT);

    logic [N_OBS-1:0] overlap;

    genvar gi;
    generate
        for (gi = 0; gi < N_OBS; gi++) begin : g_obs
            box_overlap #(
                .CAR_W (CAR_W),
                .CAR_H (CAR_H)
            ) u_box (
                .on_i       (obs_on[gi]),
                .obs_x_i    (obs_x[gi*POS_X_W +: POS_X_W]),
                .obs_y_i    (obs_y[gi*POS_Y_W +: POS_Y_W]),
                .player_x_i (player_x),
                .player_y_i (player_y),
                .hit_o      (overlap[gi])
            );
        end
    endgenerate

    state_t             state_q;
    logic [LIVES_W-1:0] lives_q;
    logic [LIVES_W-1:0] lives_d;
    logic [TICK_W-1:0]  tick_q;
    logic [TICK_W-1:0]  tick_d;
    logic [N_OBS-1:0]   hit_vec_q;
    logic [IDX_W-1:0]   hit_idx_q;
    logic               start_prev_q;
    logic               alive_q;
    logic               crash_q;
    logic               game_over_q;
    logic               tick_done;

    always_comb begin
        lives_d   = (lives_q == '0) ? '0 : lives_q - 1'b1;
        tick_d    = tick_q + 1'b1;
        tick_done = upsig && (tick_q == TICK_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lives_q      <= '0;
            tick_q       <= '0;
            hit_vec_q    <= '0;
            hit_idx_q    <= '0;
            start_prev_q <= 1'b1;   // a start already high at reset is not an edge
            alive_q      <= 1'b0;
            crash_q      <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            start_prev_q <= start;
            hit_vec_q    <= overlap;
            case (state_q)
                ST_IDLE: begin
                    if (start && !start_prev_q) begin
                        state_q <= ST_RUN;
                        lives_q <= LIVES_LD;
                        alive_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (|hit_vec_q) begin
                        state_q   <= ST_CRASH;
                        lives_q   <= lives_d;
                        hit_idx_q <= lowest_set(MAX_OBS'(hit_vec_q));
                        tick_q    <= '0;
                        alive_q   <= 1'b0;
                        crash_q   <= 1'b1;
                    end
                end
                ST_CRASH: begin
                    if (tick_done) begin
                        tick_q  <= '0;
                        crash_q <= 1'b0;
                        if (lives_q == '0) begin
                            state_q     <= ST_OVER;
                            game_over_q <= 1'b1;
                        end else begin
`ifdef RACE_CONTROLLER_GRACE_EN
                            state_q <= ST_GRACE;
`else
                            state_q <= ST_RUN;
`endif
                            alive_q <= 1'b1;
                        end
                    end else if (upsig) begin
                        tick_q <= tick_d;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_q     <= ST_IDLE;
                        game_over_q <= 1'b0;
                    end
                end
`ifdef RACE_CONTROLLER_GRACE_EN
                ST_GRACE: begin
                    if (tick_done) begin
                        tick_q  <= '0;
                        state_q <= ST_RUN;
                    end else if (upsig) begin
                        tick_q <= tick_d;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    alive_q     <= 1'b0;
                    crash_q     <= 1'b0;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign alive     = alive_q;
    assign crash     = crash_q;
    assign game_over = game_over_q;
    assign lives     = lives_q;
    assign hit_vec   = hit_vec_q;
    assign hit_idx   = hit_idx_q;

endmodule

// File: tb/tb_race_controller.sv
// Directed self-checking bench for race_controller with default parameters.
// The GRACE sequence runs only when RACE_CONTROLLER_GRACE_EN is defined.
module tb_race_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        upsig;
    logic        start;
    logic [7:0]  player_x;
    logic [9:0]  player_y;
    logic [5:0]  obs_on;
    logic [47:0] obs_x;
    logic [59:0] obs_y;
    logic        alive;
    logic        crash;
    logic        game_over;
    logic [3:0]  lives;
    logic [5:0]  hit_vec;
    logic [3:0]  hit_idx;

    int checks = 0;
    int errors = 0;

    race_controller dut (
        .clk       (clk),
        .reset     (reset),
        .upsig     (upsig),
        .start     (start),
        .player_x  (player_x),
        .player_y  (player_y),
        .obs_on    (obs_on),
        .obs_x     (obs_x),
        .obs_y     (obs_y),
        .alive     (alive),
        .crash     (crash),
        .game_over (game_over),
        .lives     (lives),
        .hit_vec   (hit_vec),
        .hit_idx   (hit_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_obs(input int idx, input logic [7:0] x, input logic [9:0] y);
        obs_x[idx*8 +: 8]  = x;
        obs_y[idx*10 +: 10] = y;
    endtask

    // Each pulse: one idle cycle, then one cycle with upsig high; returns just after that edge.
    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            upsig = 1'b0;
            tick();
            upsig = 1'b1;
            tick();
        end
        upsig = 1'b0;
    endtask

    initial begin
        reset = 1'b1; upsig = 1'b0; start = 1'b0;
        player_x = 8'd100; player_y = 10'd400;
        obs_on = '0; obs_x = '0; obs_y = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_alive", alive, 0);
        chk("reset_crash", crash, 0);
        chk("reset_over", game_over, 0);
        chk("reset_lives", lives, 0);
        chk("reset_hit_vec", hit_vec, 0);
        chk("reset_hit_idx", hit_idx, 0);
        tick();
        $display("txn reset done: alive=%0d lives=%0d", alive, lives);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_alive", alive, 1);
        chk("start_lives", lives, 3);
        $display("txn start: alive=%0d lives=%0d", alive, lives);

        // Near misses: exact boundaries and a disabled obstacle at the player position
        set_obs(0, 8'd116, 10'd400);
        set_obs(1, 8'd100, 10'd400);
        set_obs(3, 8'd84,  10'd400);
        set_obs(5, 8'd100, 10'd432);
        obs_on = 6'b101001;
        tick(); tick();
        chk("boundary_hit_vec", hit_vec, 0);
        chk("boundary_alive", alive, 1);
        $display("txn boundary: hit_vec=%b alive=%0d", hit_vec, alive);

        set_obs(2, 8'd110, 10'd420);
        obs_on = 6'b101101;
        tick();
        chk("hit2_hit_vec", hit_vec, 6'b000100);
        chk("hit2_not_yet_crash", crash, 0);
        upsig = 1'b1;
        tick();
        upsig = 1'b0;
        chk("hit2_crash", crash, 1);
        chk("hit2_alive", alive, 0);
        chk("hit2_lives", lives, 2);
        chk("hit2_idx", hit_idx, 2);
        $display("txn crash1: crash=%0d lives=%0d hit_idx=%0d", crash, lives, hit_idx);

        pulses(58);
        obs_on = '0;
        pulses(1);
        chk("crash1_59_crash", crash, 1);
        chk("crash1_59_lives", lives, 2);
        pulses(1);
        chk("crash1_60_crash", crash, 0);
        chk("crash1_60_alive", alive, 1);
        chk("crash1_60_lives", lives, 2);
        $display("txn crash1 end: crash=%0d alive=%0d lives=%0d", crash, alive, lives);

        set_obs(1, 8'd105, 10'd395);
        set_obs(4, 8'd95,  10'd410);
        obs_on = 6'b010010;
        tick();
        chk("multi_hit_vec", hit_vec, 6'b010010);
        tick();
        obs_on = '0;
        chk("multi_crash", crash, 1);
        chk("multi_lives", lives, 1);
        chk("multi_idx", hit_idx, 1);
        pulses(60);
        chk("crash2_end_alive", alive, 1);
        chk("crash2_end_lives", lives, 1);
        $display("txn crash2: lives=%0d hit_idx=%0d alive=%0d", lives, hit_idx, alive);

        obs_on = 6'b000100;
        tick(); tick();
        obs_on = '0;
        chk("crash3_crash", crash, 1);
        chk("crash3_lives", lives, 0);
        pulses(60);
        chk("over_flag", game_over, 1);
        chk("over_alive", alive, 0);
        chk("over_crash", crash, 0);
        chk("over_lives", lives, 0);
        $display("txn over: game_over=%0d lives=%0d", game_over, lives);

        obs_on = 6'b000100;
        tick(); tick(); tick();
        chk("over_ignore_hit_crash", crash, 0);
        chk("over_ignore_hit_flag", game_over, 1);
        start = 1'b1;
        tick();
        chk("over_to_idle_flag", game_over, 0);
        chk("over_to_idle_alive", alive, 0);
        tick(); tick(); tick();
        chk("held_start_alive", alive, 0);
        chk("held_start_crash", crash, 0);
        chk("held_start_lives", lives, 0);
        $display("txn idle held start: alive=%0d lives=%0d", alive, lives);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_alive", alive, 1);
        chk("restart_lives", lives, 3);
        tick();
        chk("restart_crash", crash, 1);
        chk("restart_crash_lives", lives, 2);
        $display("txn restart: crash=%0d lives=%0d", crash, lives);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midcrash_reset_crash", crash, 0);
        chk("midcrash_reset_lives", lives, 0);
        chk("midcrash_reset_hit_vec", hit_vec, 0);
        chk("midcrash_reset_idx", hit_idx, 0);
        tick(); tick();
        chk("after_reset_alive", alive, 0);
        chk("after_reset_lives", lives, 0);
        $display("txn mid-crash reset: crash=%0d lives=%0d", crash, lives);

`ifdef RACE_CONTROLLER_GRACE_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("grace_start_alive", alive, 1);
        tick();
        chk("grace_crash", crash, 1);
        chk("grace_crash_lives", lives, 2);
        pulses(60);
        chk("grace_enter_alive", alive, 1);
        chk("grace_enter_crash", crash, 0);
        pulses(59);
        chk("grace_hold_crash", crash, 0);
        chk("grace_hold_lives", lives, 2);
        pulses(1);
        chk("grace_exit_alive", alive, 1);
        tick();
        chk("grace_recrash", crash, 1);
        chk("grace_recrash_lives", lives, 1);
        $display("txn grace: crash=%0d lives=%0d", crash, lives);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
